// File: rtl/wb_uart_slave.sv
// wb_uart_slave: Wishbone register front-end for the UART.
// It buffers received bytes in a small RX FIFO and forwards written bytes to
// the uart_tx FIFO. While that FIFO is full, it holds off the bus acknowledge.
module wb_uart_slave #(
  parameter int unsigned RX_AW = 4
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_wb_cyc,
  input  logic [3:0]  i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  input  logic [7:0]  i_uart_rx_dat,
  input  logic        i_uart_received,
  output logic [7:0]  o_uart_tx_dat,
  output logic        o_uart_tx_push,
  input  logic        i_uart_tx_full,
  output logic        o_irq
);

  localparam int unsigned DEPTH = 1 << RX_AW;
  localparam int unsigned CW    = RX_AW + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_TX = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       rx_mem_q [DEPTH];
  logic [RX_AW-1:0] rd_ptr_q;
  logic [RX_AW-1:0] wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overrun_q;
  logic             irq_en_q;
  logic [7:0]       tx_byte_q;

  logic        req;
  logic        accept;
  logic        rx_empty;
  logic        rx_full;
  logic        data_wr;
  logic        tx_wait;
  logic        ctrl_wr;
  logic        status_clr;
  logic        rx_pop;
  logic        rx_push;
  logic        rx_drop;
  logic [31:0] rd_data;
  logic        unused_dat;

  assign unused_dat = ^i_wb_dat[31:8];

  // Request decode and FIFO handshake qualifiers.
  assign req        = i_wb_cyc && (|i_wb_stb);
  assign accept     = (state_q == ST_IDLE) && req && !o_wb_ack;
  assign rx_empty   = (count_q == '0);
  assign rx_full    = (count_q == CW'(DEPTH));
  assign data_wr    = accept && i_wb_we && (i_wb_addr == ADDR_DATA) && i_wb_stb[0];
  assign tx_wait    = data_wr && i_uart_tx_full;
  assign ctrl_wr    = accept && i_wb_we && (i_wb_addr == ADDR_CTRL) && i_wb_stb[0];
  assign status_clr = accept && i_wb_we && (i_wb_addr == ADDR_STATUS) && i_wb_stb[0]
                      && i_wb_dat[3];
  assign rx_pop     = accept && !i_wb_we && (i_wb_addr == ADDR_DATA) && !rx_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign rx_push    = i_uart_received && (!rx_full || rx_pop);
  assign rx_drop    = i_uart_received && rx_full && !rx_pop;

  // Read mux, sampled into o_wb_dat when a read is accepted.
  always_comb begin
    rd_data = '0;
    case (i_wb_addr)
      ADDR_DATA: begin
        if (!rx_empty) begin
          rd_data[7:0] = rx_mem_q[rd_ptr_q];
          rd_data[8]   = 1'b1;
        end
      end
      ADDR_STATUS: begin
        rd_data[0]          = rx_empty;
        rd_data[1]          = rx_full;
        rd_data[2]          = i_uart_tx_full;
        rd_data[3]          = overrun_q;
        rd_data[RX_AW+8:8]  = count_q;
      end
      ADDR_CTRL: rd_data[0] = irq_en_q;
      default: rd_data = '0;
    endcase
  end

  // RX FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge i_wb_clk) begin
    if (rx_push) begin
      rx_mem_q[wr_ptr_q] <= i_uart_rx_dat;
    end
  end

  // RX FIFO pointers, occupancy and sticky overrun flag.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (rx_push) begin
        wr_ptr_q <= wr_ptr_q + RX_AW'(1);
      end
      if (rx_pop) begin
        rd_ptr_q <= rd_ptr_q + RX_AW'(1);
      end
      if (rx_push && !rx_pop) begin
        count_q <= count_q + CW'(1);
      end else if (rx_pop && !rx_push) begin
        count_q <= count_q - CW'(1);
      end
      if (rx_drop) begin
        overrun_q <= 1'b1;
      end else if (status_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Bus FSM: accept, optionally wait for TX space, then a single ack cycle.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q        <= ST_IDLE;
      o_wb_ack       <= 1'b0;
      o_wb_dat       <= '0;
      o_uart_tx_push <= 1'b0;
      o_uart_tx_dat  <= '0;
      tx_byte_q      <= '0;
      irq_en_q       <= 1'b0;
    end else begin
      o_uart_tx_push <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (tx_wait) begin
              tx_byte_q <= i_wb_dat[7:0];
              state_q   <= ST_WAIT_TX;
            end else begin
              o_wb_ack <= 1'b1;
              o_wb_dat <= i_wb_we ? '0 : rd_data;
              if (data_wr) begin
                o_uart_tx_push <= 1'b1;
                o_uart_tx_dat  <= i_wb_dat[7:0];
              end
              if (ctrl_wr) begin
                irq_en_q <= i_wb_dat[0];
              end
              state_q <= ST_ACK;
            end
          end
        end
        ST_WAIT_TX: begin
          if (!i_wb_cyc) begin
            state_q <= ST_IDLE;
          end else if (!i_uart_tx_full) begin
            o_uart_tx_push <= 1'b1;
            o_uart_tx_dat  <= tx_byte_q;
            o_wb_ack       <= 1'b1;
            o_wb_dat       <= '0;
            state_q        <= ST_ACK;
          end
        end
        ST_ACK: begin
          o_wb_ack <= 1'b0;
          o_wb_dat <= '0;
          state_q  <= ST_IDLE;
        end
        default: begin
          o_wb_ack <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered RX interrupt, trailing the FIFO/enable state by one cycle.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= irq_en_q && !rx_empty;
    end
  end

endmodule

// File: doc/wb_uart_slave.md
Name: wb_uart_slave

Overview:
- Wishbone slave that exposes the UART to a bus master (CPU or another wishbone initiator); the responder end of the same bus that uart2wb drives as master.
- Sits between the wishbone bus and the existing uart_rx / uart_tx blocks.
- Buffers received bytes in an internal RX FIFO and pushes transmit bytes into uart_tx's FIFO, stalling the bus with a delayed ack when that FIFO is full.

Parameters:
- RX_AW, 4: RX FIFO address width; depth = 2**RX_AW bytes (16). Valid range 1..7.

Ports:
- i_wb_clk  in  1  system clock; all logic on its rising edge.
- i_wb_rst  in  1  reset, synchronous, active-high.
- i_wb_cyc  in  1  bus cycle valid.
- i_wb_stb  in  4  per-byte strobe/select; a request exists when i_wb_cyc && |i_wb_stb.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  2  word register address.
- i_wb_dat  in  32  write data.
- o_wb_dat  out  32  read data, valid while o_wb_ack = 1.
- o_wb_ack  out  1  one-cycle transfer acknowledge.
- i_uart_rx_dat  in  8  byte from uart_rx.
- i_uart_received  in  1  one-cycle strobe; i_uart_rx_dat is valid.
- o_uart_tx_dat  out  8  byte to uart_tx.
- o_uart_tx_push  out  1  one-cycle push into the uart_tx FIFO.
- i_uart_tx_full  in  1  uart_tx FIFO full.
- o_irq  out  1  RX interrupt.

Behaviour:
- Reset, synchronous:
  - o_wb_ack = 0, o_wb_dat = 0, o_uart_tx_push = 0, o_uart_tx_dat = 0, o_irq = 0.
  - RX FIFO empty (pointers and count = 0), overrun = 0, irq_en = 0, FSM = IDLE.
  - Reset asserted mid-transaction aborts it: no ack, no push, no pop.
- Register map (word address):
  - 0 DATA
    - Write with stb[0]: transmit i_wb_dat[7:0].
    - Read: [7:0] = RX head byte, [8] = valid (FIFO was non-empty). A valid read pops one byte. An empty read returns 0 and does not pop.
  - 1 STATUS (read)
    - [0] rx_empty, [1] rx_full, [2] i_uart_tx_full, [3] overrun (sticky), [RX_AW+8:8] rx count; other bits 0.
    - Write with stb[0] and dat[3] = 1 clears overrun.
  - 2 CTRL: [0] irq_en, read/write with stb[0]; other bits read 0.
  - 3: reads 0; writes are acked and have no effect.
  - Byte lanes other than stb[0] are ignored on writes.
  - A write to DATA with stb[0] = 0 is acked and does not push.
- FSM states: IDLE, WAIT_TX, ACK.
  - IDLE: request present and o_wb_ack = 0 → accept.
    - DATA write with i_uart_tx_full = 1 → WAIT_TX.
    - Any other request → perform its side effect, register o_wb_dat, go to ACK.
  - WAIT_TX:
    - i_uart_tx_full = 0 → push and go to ACK.
    - i_wb_cyc = 0 → abort to IDLE: no push, no ack.
  - ACK: o_wb_ack = 1 for exactly one cycle, then IDLE.
  - Minimum latency is request to ack in 2 cycles. Back-to-back requests are spaced at least 2 cycles apart.
- TX push:
  - o_uart_tx_push is high for exactly 1 cycle and coincides with the transition into ACK.
  - o_uart_tx_dat holds the byte from that cycle until the next push.
- RX FIFO:
  - i_uart_received pushes i_uart_rx_dat.
  - When full and no pop in the same cycle, the byte is dropped and overrun is set to 1.
  - Simultaneous push and pop when full: both happen, count stays at full, no overrun.
  - Simultaneous push and pop when empty: the pop sees valid = 0 and returns 0; the push is stored and count = 1.
  - Pointers wrap modulo 2**RX_AW. Count is RX_AW+1 bits.
- Interrupt: o_irq is registered, o_irq = irq_en && !rx_empty, one cycle after the state change.

Test Plan:
- Reset then read STATUS → ack on cycle 2 after request; o_wb_dat = 0x00000001 (rx_empty); o_irq = 0.
- Write DATA = 0x41 with i_uart_tx_full = 0 → one push cycle with o_uart_tx_dat = 0x41, ack in the same cycle. Repeat with i_uart_tx_full = 1 for 5 cycles → no ack and no push until full drops; push of 0x41 and ack on the next cycle.
- Drive received bytes 0x10, 0x11, 0x12 → STATUS count = 3. Three DATA reads → 0x110, 0x111, 0x112. A fourth read → 0x000 with no pop.
- Push 17 bytes 0x00..0x10 (RX_AW = 4) → rx_full = 1, overrun = 1. Reads return 0x100..0x10F. Write STATUS dat = 0x8 → overrun = 0.
- Set CTRL = 1, then receive 0x55 → o_irq = 1 one cycle later. Read DATA → o_irq = 0.
- Assert i_wb_rst during WAIT_TX, and separately drop i_wb_cyc during WAIT_TX → no ack and no push in either case; FSM returns to IDLE and the next request is served normally.
